bambu_mem_arbiter: RTL and testbench

Two-channel arbiter and sequencer that shares one single-port synchronous SRAM between the two master lanes of a Bambu-generated `main` core. Lane 0 and lane 1 each carry a packed oe/we/addr/wdata/size request. The block grants lanes round-robin, drives the SRAM, and returns per-lane `M_DataRdy` and `M_Rdata_ram` with configurable read/write latency. It sits between the core's `Mout_*` outputs and its `M_*` inputs, replacing the behavioural memory model used in simulation.

---
 rtl/bambu_mem_arbiter_if.sv | 27 ++
 rtl/bambu_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_bambu_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bambu_mem_arbiter_if.sv
// bambu_mem_arbiter_if: lane-side bus between a Bambu main core (master) and the SRAM arbiter (slave)
//   Mout_oe_ram/Mout_we_ram   per-lane read/write request
//   Mout_addr_ram             lane i address at [i*ADDR_W +: ADDR_W]
//   Mout_Wdata_ram            lane i write data at [i*DATA_W +: DATA_W]
//   Mout_data_ram_size        lane i access size in bits at [i*4 +: 4]
//   M_Rdata_ram               lane i read data, nonzero only in its read response cycle
//   M_DataRdy                 per-lane one-cycle completion strobe
interface bambu_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic [1:0]          Mout_oe_ram;
    logic [1:0]          Mout_we_ram;
    logic [2*ADDR_W-1:0] Mout_addr_ram;
    logic [2*DATA_W-1:0] Mout_Wdata_ram;
    logic [7:0]          Mout_data_ram_size;
    logic [2*DATA_W-1:0] M_Rdata_ram;
    logic [1:0]          M_DataRdy;
    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );
    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/bambu_mem_arbiter.sv
// bambu_mem_arbiter: round-robin two-lane arbiter and sequencer onto one single-port synchronous SRAM
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   bus            lane request/response bus (slave side)
//   sram_*         SRAM port: ce/we strobe only in ISSUE, addr/wdata/wmask hold the last grant
//   sram_rdata     SRAM read data, valid the cycle after a read strobe
//   err_both       sticky per-lane flag: oe and we seen together
//   busy           high whenever the sequencer is not idle
module bambu_mem_arbiter #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MEMSIZE     = 64,
    parameter int unsigned READ_DELAY  = 2,
    parameter int unsigned WRITE_DELAY = 1,
    localparam int unsigned SRAM_AW    = $clog2(MEMSIZE)
) (
    input  logic                clock,
    input  logic                reset,
    bambu_mem_arbiter_if.slave  bus,
    output logic                sram_ce,
    output logic                sram_we,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W-1:0]   sram_wmask,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic [1:0]          err_both,
    output logic                busy
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(READ_DELAY - 2);
    localparam logic [CNT_W-1:0] WR_WAIT = CNT_W'(WRITE_DELAY - 1);

    // CAP is the mandatory first post-issue cycle of every read, where sram_rdata is captured
    typedef enum logic [2:0] {IDLE, ISSUE, CAP, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic               lane_q, lane_d;
    logic               op_q, op_d;
    logic               last_grant_q, last_grant_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;

    logic [1:0]         valid;
    logic               grant;
    logic [SRAM_AW-1:0] lane_off   [2];
    logic [DATA_W-1:0]  lane_mask  [2];
    logic [DATA_W-1:0]  lane_wdata [2];

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic [31:0] off;
        logic [3:0]  size;
        // Unsigned wrap turns addresses below BASE_ADDR into huge offsets, so one compare covers both bounds
        assign off           = 32'(bus.Mout_addr_ram[i*ADDR_W +: ADDR_W]) - BASE_ADDR;
        assign size          = bus.Mout_data_ram_size[i*4 +: 4];
        assign valid[i]      = (bus.Mout_oe_ram[i] ^ bus.Mout_we_ram[i]) && off < MEMSIZE;
        assign lane_off[i]   = SRAM_AW'(off);
        assign lane_mask[i]  = 32'(size) >= DATA_W ? '1 : DATA_W'((32'd1 << size) - 32'd1);
        assign lane_wdata[i] = bus.Mout_Wdata_ram[i*DATA_W +: DATA_W];
    end

    assign grant = valid == 2'b11 ? ~last_grant_q : valid[1];

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q | (bus.Mout_oe_ram & bus.Mout_we_ram);
        case (state_q)
            IDLE: if (|valid) begin
                state_d      = ISSUE;
                lane_d       = grant;
                last_grant_d = grant;
                op_d         = bus.Mout_we_ram[grant];
                addr_d       = lane_off[grant];
                wdata_d      = lane_wdata[grant];
                mask_d       = lane_mask[grant];
            end
            ISSUE: begin
                cnt_d   = op_q ? WR_WAIT : RD_WAIT;
                state_d = !op_q ? CAP : WR_WAIT == '0 ? RESP : WAIT;
            end
            CAP: begin
                rdata_d = sram_rdata;
                state_d = cnt_q == '0 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CNT_W'(1) ? RESP : WAIT;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= 1'b0;
            op_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign busy            = state_q != IDLE;
    assign sram_ce         = state_q == ISSUE;
    assign sram_we         = sram_ce & op_q;
    assign sram_addr       = addr_q;
    assign sram_wdata      = wdata_q;
    assign sram_wmask      = mask_q;
    assign err_both        = err_q;
    assign bus.M_DataRdy   = state_q == RESP ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.M_Rdata_ram = state_q == RESP && !op_q ? (lane_q ? {rdata_q, DATA_W'(0)} : {DATA_W'(0), rdata_q}) : '0;
endmodule

// File: tb/tb_bambu_mem_arbiter.sv
// tb_bambu_mem_arbiter: table-driven plus scoreboard bench for bambu_mem_arbiter with default parameters
module tb_bambu_mem_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b1;
    logic       sram_ce, sram_we;
    logic [5:0] sram_addr;
    logic [7:0] sram_wdata, sram_wmask;
    logic [7:0] sram_rdata = 8'h00;
    logic [1:0] err_both;
    logic       busy;
    logic [7:0] mem [64];
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        logic       lane;
        logic       oe;
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [3:0] size;
        logic [7:0] exp_rdata;
        logic [7:0] exp_mask;
    } vec_t;

    typedef struct {
        logic       lane;
        logic       rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb [$];
    vec_t tbl [12];

    bambu_mem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    bambu_mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wmask (sram_wmask),
        .sram_rdata (sram_rdata),
        .err_both   (err_both),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[5] <= 8'hA5;
            mem[9] <= 8'h3C;
        end else if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else sram_rdata <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.M_DataRdy != 2'b00) begin
            chk("rdy_onehot", 32'(bus.M_DataRdy == 2'b11), 0);
            chk("rdy_busy", 32'(busy), 1);
        end
    end

    task automatic set_lane(input int l, input logic oe, input logic we, input logic [6:0] addr,
                            input logic [7:0] wdata, input logic [3:0] size);
        bus.Mout_oe_ram[l]              = oe;
        bus.Mout_we_ram[l]              = we;
        bus.Mout_addr_ram[l*7 +: 7]     = addr;
        bus.Mout_Wdata_ram[l*8 +: 8]    = wdata;
        bus.Mout_data_ram_size[l*4 +: 4] = size;
    endtask

    task automatic await_rdy(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (bus.M_DataRdy != 2'b00) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic compare_resp();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: response with no expectation queued");
            return;
        end
        e = sb.pop_front();
        chk("rdy_lane", 32'(bus.M_DataRdy), e.lane ? 2 : 1);
        chk("rdata", 32'(bus.M_Rdata_ram), e.rd ? (e.lane ? {16'h0, e.rdata, 8'h00} : {24'h0, e.rdata}) : 32'h0);
    endtask

    task automatic run_req(input vec_t v);
        int lat;
        set_lane(int'(v.lane), v.oe, v.we, v.addr, v.wdata, v.size);
        sb.push_back('{v.lane, v.oe, v.exp_rdata});
        @(negedge clock);
        chk("issue_ce", 32'(sram_ce), 1);
        chk("issue_we", 32'(sram_we), 32'(v.we));
        chk("issue_addr", 32'(sram_addr), 32'(v.addr));
        chk("issue_busy", 32'(busy), 1);
        if (v.we) begin
            chk("issue_mask", 32'(sram_wmask), 32'(v.exp_mask));
            chk("issue_wdata", 32'(sram_wdata), 32'(v.wdata));
        end
        await_rdy(20, lat);
        chk("latency", 32'(lat + 1), v.oe ? 3 : 2);
        compare_resp();
        set_lane(int'(v.lane), 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        @(negedge clock);
        chk("rdy_one_cycle", 32'(bus.M_DataRdy), 0);
    endtask

    task automatic dual(input logic [6:0] a0, input logic [7:0] d0, input logic [6:0] a1,
                        input logic [7:0] d1, input logic first);
        int lat;
        set_lane(0, 1'b1, 1'b0, a0, 8'h00, 4'd8);
        set_lane(1, 1'b1, 1'b0, a1, 8'h00, 4'd8);
        sb.push_back('{first, 1'b1, first ? d1 : d0});
        sb.push_back('{~first, 1'b1, first ? d0 : d1});
        await_rdy(20, lat);
        chk("dual_lat_first", 32'(lat), 3);
        compare_resp();
        set_lane(int'(first), 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        await_rdy(20, lat);
        chk("dual_lat_second", 32'(lat), 4);
        compare_resp();
        set_lane(int'(~first), 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        @(negedge clock);
    endtask

    task automatic idle_probe(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            chk({name, "_ce"}, 32'(sram_ce), 0);
            chk({name, "_rdy"}, 32'(bus.M_DataRdy), 0);
            chk({name, "_busy"}, 32'(busy), 0);
        end
    endtask

    initial begin
        int lat;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 7'd5,  8'h00, 4'd8,  8'hA5, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 7'd9,  8'hFF, 4'd4,  8'h00, 8'h0F};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 7'd9,  8'h00, 4'd8,  8'h3F, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 7'd9,  8'h00, 4'd8,  8'h3F, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 7'd20, 8'h96, 4'd8,  8'h00, 8'hFF};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 7'd20, 8'h00, 4'd8,  8'h96, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 7'd20, 8'h00, 4'd0,  8'h00, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 7'd20, 8'h00, 4'd8,  8'h96, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 7'd63, 8'hC3, 4'd15, 8'h00, 8'hFF};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 7'd63, 8'h00, 4'd8,  8'hC3, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 7'd0,  8'h5A, 4'd3,  8'h00, 8'h07};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 7'd0,  8'h00, 4'd8,  8'h02, 8'h00};
        bus.Mout_oe_ram        = 2'b00;
        bus.Mout_we_ram        = 2'b00;
        bus.Mout_addr_ram      = '0;
        bus.Mout_Wdata_ram     = '0;
        bus.Mout_data_ram_size = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ce", 32'(sram_ce), 0);
        chk("rst_we", 32'(sram_we), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_wmask", 32'(sram_wmask), 0);
        chk("rst_rdy", 32'(bus.M_DataRdy), 0);
        chk("rst_rdata", 32'(bus.M_Rdata_ram), 0);
        chk("rst_err", 32'(err_both), 0);
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) run_req(tbl[i]);

        dual(7'd5, 8'hA5, 7'd9, 8'h3F, 1'b0);
        run_req('{1'b0, 1'b1, 1'b0, 7'd20, 8'h00, 4'd8, 8'h96, 8'h00});
        dual(7'd0, 8'h02, 7'd63, 8'hC3, 1'b1);

        set_lane(0, 1'b1, 1'b1, 7'd5, 8'h11, 4'd8);
        idle_probe("both_oe_we", 4);
        chk("err_set", 32'(err_both), 32'h1);
        set_lane(0, 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        @(negedge clock);
        chk("err_sticky", 32'(err_both), 32'h1);

        set_lane(1, 1'b1, 1'b0, 7'd64, 8'h00, 4'd8);
        idle_probe("oor_64", 4);
        set_lane(1, 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        set_lane(0, 1'b0, 1'b1, 7'd127, 8'h77, 4'd8);
        idle_probe("oor_127", 4);
        set_lane(0, 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        @(negedge clock);

        set_lane(0, 1'b1, 1'b0, 7'd5, 8'h00, 4'd8);
        repeat (2) @(negedge clock);
        chk("mid_busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ce", 32'(sram_ce), 0);
        chk("mid_rst_addr", 32'(sram_addr), 0);
        chk("mid_rst_rdy", 32'(bus.M_DataRdy), 0);
        chk("mid_rst_rdata", 32'(bus.M_Rdata_ram), 0);
        chk("mid_rst_err", 32'(err_both), 0);
        set_lane(0, 1'b0, 1'b0, 7'd0, 8'h00, 4'd0);
        await_rdy(3, lat);
        chk("mid_rst_no_rdy", 32'(lat), 32'hFFFF_FFFF);
        reset = 1'b0;
        @(negedge clock);
        run_req(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
